// File: rtl/conv_addr_sequencer_pkg.sv
// conv_addr_sequencer_pkg
//   Shared definitions for the conv-layer address sequencer:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - helpers deriving counter widths and the per-output-channel and
//     per-layer weight block sizes from the layer geometry.
package conv_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Taps accumulated per output value: K*K*CH.
  function automatic int unsigned taps_per_out(input int unsigned k,
                                               input int unsigned ch);
    return k * k * ch;
  endfunction

  // Weight words for the whole layer: OUT_CH*K*K*CH.
  function automatic int unsigned weights_per_layer(input int unsigned och,
                                                    input int unsigned k,
                                                    input int unsigned ch);
    return och * k * k * ch;
  endfunction

endpackage

// File: rtl/conv_addr_sequencer_loop_counter.sv
// conv_loop_counter
//   Wrap counter used as one level of the conv loop nest.
//   Counts 0..MAX-1 on inc, wraps to 0 and raises carry (combinational,
//   same cycle as the wrapping inc) so the next-outer level can advance.
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   clr    in   synchronous clear (priority over inc)
//   inc    in   advance by one
//   count  out  current value
//   carry  out  inc while at MAX-1
module conv_loop_counter #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         carry
);

  logic at_max;

  assign at_max = (count == W'(MAX - 1));
  assign carry  = inc && at_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer
//   Self-sequencing conv-layer address generator. Walks the loop nest
//   j,k (output pixel), i (output channel), m,n (kernel tap), l (input
//   channel), outer to inner, and emits one {s,w,b,save} tuple per accepted
//   cycle over a valid/ready handshake, flagging padding taps and the
//   first/last tap of each accumulation.
// Configuration
//   CONV_PAD_SKIP_EN : when defined, padding tuples that carry neither first
//                      nor last are consumed internally (out_valid=0) instead
//                      of being emitted.
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a layer sweep (sampled in IDLE only)
//   busy       out  high while sweeping
//   done       out  one-cycle pulse after the final tuple is accepted
//   out_valid  out  tuple valid
//   out_ready  in   consumer accepts tuple
//   s_addr     out  input feature address (0 on padding taps)
//   w_addr     out  weight address
//   b_addr     out  bias address
//   save_addr  out  result address
//   pad        out  tap lies outside the image
//   first      out  first tap of an accumulation
//   last       out  last tap of an accumulation
module conv_addr_sequencer
  import conv_addr_sequencer_pkg::*;
#(
  parameter int unsigned CONV_DIM_IMG    = 32,
  parameter int unsigned CONV_DIM_KERNEL = 5,
  parameter int unsigned CONV_DIM_CH     = 3,
  parameter int unsigned CONV_OUT_CH     = 32,
  parameter int unsigned CONV_DIM_OUT    = 32,
  parameter int unsigned STRIDE          = 1,
  parameter int unsigned PADDING         = 2,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] save_addr,
  output logic              pad,
  output logic              first,
  output logic              last
);

  localparam int unsigned JW   = cnt_w(CONV_DIM_OUT);
  localparam int unsigned IW   = cnt_w(CONV_OUT_CH);
  localparam int unsigned MW   = cnt_w(CONV_DIM_KERNEL);
  localparam int unsigned LW   = cnt_w(CONV_DIM_CH);
  localparam int unsigned KKCH = taps_per_out(CONV_DIM_KERNEL, CONV_DIM_CH);
  localparam int unsigned AW2  = ADDR_W + 2;

  seq_state_t state_q, state_d;

  logic          adv;       // step the loop nest
  logic          take;      // load output register with the current tuple
  logic          retire;    // drop out_valid after the final tuple
  logic          gen_done_q;

  logic [JW-1:0] j_cnt, k_cnt;
  logic [IW-1:0] i_cnt;
  logic [MW-1:0] m_cnt, n_cnt;
  logic [LW-1:0] l_cnt;
  logic          l_carry, n_carry, m_carry, i_carry, k_carry, j_carry;
  logic          cnt_clr;

  // ---------------------------------------------------------------------
  // Loop nest: counters hold the coordinates of the next tuple to load.
  // After the final advance every level wraps, so they rest at zero.
  // ---------------------------------------------------------------------
  assign cnt_clr = (state_q == ST_DONE);

  conv_loop_counter #(.MAX(CONV_DIM_CH), .W(LW)) u_l (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(adv),
    .count(l_cnt), .carry(l_carry));
  conv_loop_counter #(.MAX(CONV_DIM_KERNEL), .W(MW)) u_n (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(l_carry),
    .count(n_cnt), .carry(n_carry));
  conv_loop_counter #(.MAX(CONV_DIM_KERNEL), .W(MW)) u_m (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(n_carry),
    .count(m_cnt), .carry(m_carry));
  conv_loop_counter #(.MAX(CONV_OUT_CH), .W(IW)) u_i (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(m_carry),
    .count(i_cnt), .carry(i_carry));
  conv_loop_counter #(.MAX(CONV_DIM_OUT), .W(JW)) u_k (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(i_carry),
    .count(k_cnt), .carry(k_carry));
  conv_loop_counter #(.MAX(CONV_DIM_OUT), .W(JW)) u_j (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(k_carry),
    .count(j_cnt), .carry(j_carry));

  // ---------------------------------------------------------------------
  // Address math for the tuple at the current counter position.
  // ---------------------------------------------------------------------
  logic signed [AW2-1:0] row, col;
  logic [ADDR_W-1:0]     s_d, w_d, b_d, save_d;
  logic                  pad_d, first_d, last_d, emit_d;

  always_comb begin
    row = $signed(AW2'(STRIDE)) * $signed(AW2'(j_cnt))
        + $signed(AW2'(m_cnt)) - $signed(AW2'(PADDING));
    col = $signed(AW2'(STRIDE)) * $signed(AW2'(k_cnt))
        + $signed(AW2'(n_cnt)) - $signed(AW2'(PADDING));

    pad_d = row[AW2-1] || (row >= $signed(AW2'(CONV_DIM_IMG)))
         || col[AW2-1] || (col >= $signed(AW2'(CONV_DIM_IMG)));

    // Low ADDR_W bits of the signed product equal those of the unsigned
    // modular product, so the truncated address is computed directly.
    s_d = pad_d ? '0
        : (row[ADDR_W-1:0] * ADDR_W'(CONV_DIM_IMG) + col[ADDR_W-1:0])
          * ADDR_W'(CONV_DIM_CH) + ADDR_W'(l_cnt);

    w_d = ADDR_W'(i_cnt) * ADDR_W'(KKCH)
        + (ADDR_W'(m_cnt) * ADDR_W'(CONV_DIM_KERNEL) + ADDR_W'(n_cnt))
          * ADDR_W'(CONV_DIM_CH)
        + ADDR_W'(l_cnt);

    b_d = ADDR_W'(i_cnt);

    save_d = ADDR_W'(i_cnt)
           + (ADDR_W'(j_cnt) * ADDR_W'(CONV_DIM_OUT) + ADDR_W'(k_cnt))
             * ADDR_W'(CONV_OUT_CH);

    first_d = (m_cnt == '0) && (n_cnt == '0) && (l_cnt == '0);
    last_d  = (m_cnt == MW'(CONV_DIM_KERNEL - 1))
           && (n_cnt == MW'(CONV_DIM_KERNEL - 1))
           && (l_cnt == LW'(CONV_DIM_CH - 1));

`ifdef CONV_PAD_SKIP_EN
    // Framing taps are always emitted so accumulators still clear/commit.
    emit_d = !(pad_d && !first_d && !last_d);
`else
    emit_d = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    take    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          adv     = 1'b1;
          take    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!out_valid || out_ready) begin
          if (gen_done_q) begin
            // Every tuple has been loaded; this slot retires the final one.
            retire = 1'b1;
            if (out_valid) begin
              state_d = ST_DONE;
            end
          end else begin
            adv  = 1'b1;
            take = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // Set when the advance that loads the final tuple wraps the outermost loop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_done_q <= 1'b0;
    end else if (adv && j_carry) begin
      gen_done_q <= 1'b1;
    end else if (state_q != ST_RUN) begin
      gen_done_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Output register: holds while out_valid && !out_ready.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      s_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      save_addr <= '0;
      pad       <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
    end else if (take) begin
      out_valid <= emit_d;
      s_addr    <= s_d;
      w_addr    <= w_d;
      b_addr    <= b_d;
      save_addr <= save_d;
      pad       <= pad_d;
      first     <= first_d;
      last      <= last_d;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
